// File: rtl/wb_regfile.sv
// Write-back register file: two combinational read ports with same-cycle write bypass,
// R0 hard-wired to zero, and a post-reset sequencer that zeroes the array one entry per cycle.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic              busy
);

   localparam int NREGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              busy_q, busy_d;

   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_waddr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic [DATA_W-1:0] mem_q [NREGS];

   logic              re_vec    [2];
   logic [ADDR_W-1:0] raddr_vec [2];
   logic [DATA_W-1:0] rdata_vec [2];

   always_ff @(posedge clk) begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
   end

   // The clear pointer starts at 1 because entry 0 is never read.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      busy_d    = busy_q;
      if (rst) begin
         state_d   = ST_CLEAR;
         clr_ptr_d = ADDR_W'(1);
         busy_d    = 1'b1;
      end else if (state_q == ST_CLEAR) begin
         clr_ptr_d = clr_ptr_q + ADDR_W'(1);
         if (clr_ptr_q == LAST_IDX) begin
            state_d = ST_RUN;
            busy_d  = 1'b0;
         end
      end
   end

   // One shared array write port: the clear sequencer owns it while clearing, the pipeline afterwards.
   always_comb begin
      mem_we_d    = 1'b0;
      mem_waddr_d = clr_ptr_q;
      mem_wdata_d = '0;
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            mem_we_d = 1'b1;
         end else if (we && (waddr != '0)) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = waddr;
            mem_wdata_d = wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we_d) begin
         mem_q[mem_waddr_d] <= mem_wdata_d;
      end
   end

   assign re_vec[0]    = re1;
   assign re_vec[1]    = re2;
   assign raddr_vec[0] = raddr1;
   assign raddr_vec[1] = raddr2;

   // Reads return zero while clearing so no uninitialised storage is ever visible.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata_vec[p] = '0;
         if ((state_q == ST_RUN) && re_vec[p] && (raddr_vec[p] != '0)) begin
            if (we && (waddr == raddr_vec[p])) begin
               rdata_vec[p] = wdata;
            end else begin
               rdata_vec[p] = mem_q[raddr_vec[p]];
            end
         end
      end
   end

   assign rdata1 = rdata_vec[0];
   assign rdata2 = rdata_vec[1];
   assign busy   = busy_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, clear/reset sequences,
// and random traffic compared against a behavioural register-file model.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic        busy;

   int vectors;
   int miscompares;

   logic [31:0] model_mem [32];
   int          model_clear_left;
   bit          model_valid;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        re1;
      logic [4:0]  raddr1;
      logic        re2;
      logic [4:0]  raddr2;
      logic [31:0] exp_rd1;
      logic [31:0] exp_rd2;
      logic        exp_busy;
   } vec_t;

   vec_t table_v [10];

   wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs on the falling edge and let combinational outputs settle.
   task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wa,
                                input logic [31:0] wd, input logic r1, input logic [4:0] a1,
                                input logic r2, input logic [4:0] a2);
      @(negedge clk);
      rst    = r;
      we     = w;
      waddr  = wa;
      wdata  = wd;
      re1    = r1;
      raddr1 = a1;
      re2    = r2;
      raddr2 = a2;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic r, input logic [4:0] a);
      if (model_clear_left > 0) return 32'h0;
      if (!r || a == 5'd0) return 32'h0;
      if (we && waddr == a) return wdata;
      return model_mem[a];
   endfunction

   task automatic checkModel(input string tag);
      if (model_valid) begin
         checkOutput({tag, "_rd1"}, rdata1, modelRead(re1, raddr1));
         checkOutput({tag, "_rd2"}, rdata2, modelRead(re2, raddr2));
         checkOutput({tag, "_busy"}, {31'b0, busy}, {31'b0, model_clear_left > 0});
      end
   endtask

   // Advance through the rising edge and apply the same edge to the model.
   task automatic clockModel();
      @(posedge clk);
      if (rst) begin
         model_clear_left = 31;
         model_valid      = 1'b1;
      end else if (model_clear_left > 0) begin
         model_mem[32 - model_clear_left] = 32'h0;
         model_clear_left--;
      end else if (we && waddr != 5'd0) begin
         model_mem[waddr] = wdata;
      end
   endtask

   // Runs the clear phase with writes to r7 attempted throughout; returns busy-high sample count.
   task automatic runClear(output int cnt);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b0, model_clear_left > 0, 5'd7, 32'hAA, 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)), 1'b1, 5'd7);
         checkModel("clear");
         if (!busy) begin
            clockModel();
            return;
         end
         cnt++;
         clockModel();
      end
      $display("[TB] FAIL busy_timeout: busy still %b after %0d cycles, expected 0", busy, cnt);
      miscompares++;
   endtask

   initial begin
      int cnt;
      vectors          = 0;
      miscompares      = 0;
      model_valid      = 1'b0;
      model_clear_left = 0;
      for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;

      table_v[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        1'b0};
      table_v[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      table_v[2] = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        1'b0};
      table_v[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd3,  32'h0,        32'h0,        1'b0};
      table_v[4] = '{1'b1, 5'd9,  32'h55,       1'b1, 5'd9,  1'b0, 5'd9,  32'h55,       32'h0,        1'b0};
      table_v[5] = '{1'b1, 5'd9,  32'h66,       1'b0, 5'd9,  1'b1, 5'd9,  32'h0,        32'h66,       1'b0};
      table_v[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd9,  32'h66,       32'h66,       1'b0};
      table_v[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 1'b1, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
      table_v[8] = '{1'b1, 5'd1,  32'hA5A5A5A5, 1'b1, 5'd31, 1'b1, 5'd1,  32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0};
      table_v[9] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b1, 5'd7,  32'hA5A5A5A5, 32'h0,        1'b0};

      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      clockModel();
      runClear(cnt);
      checkOutput("busy_len", 32'(cnt), 32'd31);

      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7);
      checkOutput("r5_after_clear", rdata1, 32'h0);
      checkOutput("r7_write_dropped", rdata2, 32'h0);
      clockModel();

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, table_v[i].we, table_v[i].waddr, table_v[i].wdata,
                       table_v[i].re1, table_v[i].raddr1, table_v[i].re2, table_v[i].raddr2);
         checkOutput($sformatf("vec%0d_rd1", i), rdata1, table_v[i].exp_rd1);
         checkOutput($sformatf("vec%0d_rd2", i), rdata2, table_v[i].exp_rd2);
         checkOutput($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, table_v[i].exp_busy});
         clockModel();
      end

      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                       1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
         checkModel("rand");
         clockModel();
      end

      // Reset re-asserted part-way through a clear run.
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      clockModel();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, 5'd4, 32'h1234, 1'b1, 5'd4, 1'b1, 5'd9);
         checkModel("clear_pre");
         clockModel();
      end
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      clockModel();
      runClear(cnt);
      checkOutput("busy_len_restart", 32'(cnt), 32'd31);
      for (int a = 1; a < 32; a++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b0, 5'd0);
         checkOutput($sformatf("zero_r%0d", a), rdata1, 32'h0);
         clockModel();
      end

      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                       1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
         checkModel("rand2");
         clockModel();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
